// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter sharing one slave port between NUM_MASTERS masters,
// with lock-based grant hold, idle-grant watchdog and interrupt routing to the last commander.
module wb_rr_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 2,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned TIMEOUT     = 1024,
  parameter int unsigned IRQ_ADDR    = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS-1:0]            m_lock_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]            m_irq_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [ADDR_WIDTH-1:0]             s_adr_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  input  logic                              s_ack_i,
  input  logic [DATA_WIDTH-1:0]             s_dat_i,
  input  logic                              s_irq_i,
  output logic [NUM_MASTERS-1:0]            gnt_o,
  output logic                              wdt_o
);

  localparam int unsigned IdxW = $clog2(NUM_MASTERS);
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = (TIMEOUT > 0) ? CntW'(TIMEOUT - 1) : '0;

  typedef enum logic {StIdle, StOwned} state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        owner_q, owner_d;
  logic [IdxW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]        irq_owner_q, irq_owner_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [CntW-1:0]        wdt_cnt_q, wdt_cnt_d;
  logic                   wdt_q, wdt_d;

  logic                   found;
  logic [IdxW-1:0]        sel;
  logic [IdxW-1:0]        cand;
  logic                   own_cyc, own_lock, wdt_fire, irq_claim;

  // First requester strictly after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = 1; i <= int'(NUM_MASTERS); i++) begin
      cand = IdxW'((int'(rr_ptr_q) + i) % int'(NUM_MASTERS));
      if (!found && m_cyc_i[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign own_cyc   = m_cyc_i[owner_q];
  assign own_lock  = m_lock_i[owner_q];
  assign wdt_fire  = (TIMEOUT != 0) && !own_cyc && (wdt_cnt_q == CntMax);
  assign irq_claim = s_cyc_o & s_stb_o & s_we_o & s_ack_i &
                     (s_adr_o == ADDR_WIDTH'(IRQ_ADDR));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    irq_owner_d = irq_owner_q;
    wdt_cnt_d   = '0;
    wdt_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d    = StOwned;
          owner_d    = sel;
          gnt_d      = '0;
          gnt_d[sel] = 1'b1;
        end
      end
      StOwned: begin
        if (!own_cyc && TIMEOUT != 0) begin
          wdt_cnt_d = (wdt_cnt_q == CntMax) ? wdt_cnt_q : wdt_cnt_q + 1'b1;
        end
        // Lock only defers the normal release; the watchdog still fires.
        if ((!own_cyc && !own_lock) || wdt_fire) begin
          state_d  = StIdle;
          gnt_d    = '0;
          rr_ptr_d = owner_q;
        end
        wdt_d = wdt_fire;
        if (irq_claim) irq_owner_d = owner_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      rr_ptr_q    <= IdxW'(NUM_MASTERS - 1);
      irq_owner_q <= '0;
      gnt_q       <= '0;
      wdt_cnt_q   <= '0;
      wdt_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      irq_owner_q <= irq_owner_d;
      gnt_q       <= gnt_d;
      wdt_cnt_q   <= wdt_cnt_d;
      wdt_q       <= wdt_d;
    end
  end

  // Reset gates the combinational paths so everything drops immediately.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    m_ack_o = '0;
    m_irq_o = '0;
    if (!rst_i) begin
      if (state_q == StOwned) begin
        s_cyc_o          = m_cyc_i[owner_q];
        s_stb_o          = m_stb_i[owner_q];
        s_we_o           = m_we_i[owner_q];
        s_adr_o          = m_adr_i[owner_q*ADDR_WIDTH +: ADDR_WIDTH];
        s_dat_o          = m_dat_i[owner_q*DATA_WIDTH +: DATA_WIDTH];
        m_ack_o[owner_q] = s_ack_i;
      end
      m_irq_o[irq_owner_q] = s_irq_i;
    end
  end

  assign m_dat_o = s_dat_i;
  assign gnt_o   = gnt_q;
  assign wdt_o   = wdt_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: two masters, TIMEOUT=16, CMDR at address 2.
module tb_wb_rr_arbiter;

  logic       clk_i, rst_i;
  logic [1:0] m_cyc, m_stb, m_we, m_lock, m_ack, m_irq, gnt;
  logic [3:0] m_adr;
  logic [15:0] m_dat;
  logic [7:0] m_dat_o, s_dat_o, s_dat_i;
  logic [1:0] s_adr_o;
  logic       s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_irq_i, wdt;

  int vectors = 0;
  int miscompares = 0;

  wb_rr_arbiter #(
    .ADDR_WIDTH(2), .DATA_WIDTH(8), .NUM_MASTERS(2), .TIMEOUT(16), .IRQ_ADDR(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_lock_i(m_lock),
    .m_adr_i(m_adr), .m_dat_i(m_dat),
    .m_ack_o(m_ack), .m_dat_o(m_dat_o), .m_irq_o(m_irq),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i), .s_irq_i(s_irq_i),
    .gnt_o(gnt), .wdt_o(wdt)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0; m_lock = '0;
    m_adr = '0; m_dat = '0; s_ack_i = 1'b0; s_dat_i = 8'h5A; s_irq_i = 1'b0;
    #2 rst_i = 1'b1;
    step(); step();
    s_ack_i = 1'b1; s_irq_i = 1'b1;
    #1;
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_scyc", {s_cyc_o, s_stb_o, s_we_o}, 3'b000);
    chk("rst_ack_irq", {m_ack, m_irq}, 4'b0000);
    chk("rst_wdt", wdt, 1'b0);
    chk("dat_mirror", m_dat_o, 8'h5A);
    s_ack_i = 1'b0; s_irq_i = 1'b0;
    @(negedge clk_i) rst_i = 1'b0;

    // Single requester: master0 writes 0xC0 to addr 0
    step();
    m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01; m_adr = 4'b00_00; m_dat = 16'h00C0;
    #1 chk("lat_gnt", gnt, 2'b00);
    step();
    chk("single_gnt", gnt, 2'b01);
    chk("single_ctl", {s_cyc_o, s_stb_o, s_we_o}, 3'b111);
    chk("single_adr_dat", {s_adr_o, s_dat_o}, {2'd0, 8'hC0});
    s_ack_i = 1'b1; m_cyc[1] = 1'b1;
    #1 chk("single_ack", m_ack, 2'b01);
    step();
    m_cyc[0] = 1'b0; m_stb = '0; m_we = '0; s_ack_i = 1'b0;
    step();
    chk("rel_idle", gnt, 2'b00);
    step();
    chk("rr_m1", gnt, 2'b10);
    chk("m1_cyc", s_cyc_o, 1'b1);
    m_cyc = 2'b11;
    step();
    chk("m1_hold", gnt, 2'b10);
    m_cyc = 2'b01;
    step();
    chk("m1_rel", gnt, 2'b00);
    m_cyc = 2'b11;
    step();
    chk("rr_m0_again", gnt, 2'b01);
    m_cyc = 2'b10;
    step(); step();
    chk("rr_m1_again", gnt, 2'b10);
    m_cyc = 2'b00;
    step();

    // Lock: master1 CMDR write, 5-cycle gap, status read while master0 waits
    m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b10; m_lock = 2'b10;
    m_adr = 4'b10_00; m_dat = 16'h0100;
    step();
    chk("lock_gnt", gnt, 2'b10);
    chk("lock_adr_dat", {s_adr_o, s_dat_o}, {2'd2, 8'h01});
    s_ack_i = 1'b1;
    #1 chk("lock_ack", m_ack, 2'b10);
    step();
    s_ack_i = 1'b0; m_cyc = 2'b01; m_stb = 2'b00; m_we = 2'b00;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("lock_gap", {gnt, m_ack}, {2'b10, 2'b00});
    end
    m_cyc = 2'b11; m_stb = 2'b10; s_dat_i = 8'h3C; s_ack_i = 1'b1;
    #1;
    chk("lock_read", {m_ack, m_dat_o, s_we_o}, {2'b10, 8'h3C, 1'b0});
    step();
    m_cyc = 2'b01; m_stb = 2'b00; m_lock = 2'b00; s_ack_i = 1'b0;
    step();
    chk("lock_rel", gnt, 2'b00);
    step();
    chk("lock_m0", gnt, 2'b01);

    // IRQ routing: owner of last CMDR write gets the interrupt
    m_stb = 2'b01; m_we = 2'b00; m_adr = 4'b00_11; s_ack_i = 1'b1; s_irq_i = 1'b1;
    #1 chk("irq_m1", m_irq, 2'b10);
    step();
    chk("irq_after_read", m_irq, 2'b10);
    m_we = 2'b01; m_adr = 4'b00_10;
    step();
    chk("irq_m0", m_irq, 2'b01);
    m_cyc = '0; m_stb = '0; m_we = '0; s_ack_i = 1'b0;
    step();
    chk("irq_kept", m_irq, 2'b01);
    s_irq_i = 1'b0;

    // Watchdog: master0 holds lock with cyc low
    m_cyc = 2'b01; m_lock = 2'b01;
    step();
    chk("wdt_gnt", gnt, 2'b01);
    m_cyc = 2'b10;
    for (int i = 1; i <= 15; i++) begin
      step();
      chk("wdt_hold", {gnt, wdt}, 3'b010);
    end
    step();
    chk("wdt_fire", {gnt, wdt}, 3'b001);
    step();
    chk("wdt_next", {gnt, wdt}, 3'b100);
    m_cyc = 2'b00; m_lock = 2'b00;
    step();

    // Reset mid-transfer, then contention from reset
    m_cyc = 2'b11; m_stb = 2'b11;
    step();
    chk("pre_rst_gnt", {gnt, s_stb_o}, 3'b011);
    s_ack_i = 1'b1;
    #2 rst_i = 1'b1;
    #1;
    chk("mid_rst", {gnt, s_cyc_o, s_stb_o, m_ack}, 6'b0);
    s_ack_i = 1'b0;
    @(negedge clk_i) rst_i = 1'b0;
    step();
    chk("post_rst_m0", gnt, 2'b01);
    m_cyc = 2'b10; m_stb = 2'b10;
    step(); step();
    chk("post_rst_m1", gnt, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
